// File: rtl/pio_param_out_pkg.sv
// Shared register map, bit positions and control-register layout for the
// HPS-to-fabric output PIO.
package pio_param_out_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_COMMIT = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int unsigned ST_VALID   = 0;
  localparam int unsigned ST_OVERRUN = 1;
  localparam int unsigned ST_DONE    = 2;
  localparam int unsigned ST_CNT_LSB = 16;

  localparam int unsigned CTRL_AUTO_COMMIT = 0;
  localparam int unsigned CTRL_IRQ_EN      = 1;

  // Field order gives auto_commit at bit 0 and irq_en at bit 1.
  typedef struct packed {
    logic irq_en;
    logic auto_commit;
  } ctrl_t;

endpackage

// File: rtl/pio_hs_out_reg.sv
// Valid/ready holding register: loads a word on commit, presents it until the
// fabric accepts, and flags an overrun when a held word is replaced unaccepted.
module pio_hs_out_reg #(
  parameter int unsigned     WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] out_port,
  output logic             out_valid,
  output logic             overrun,
  output logic             accept
);

  assign accept = out_valid & out_ready;

  // Word/valid/overrun state; a load in the accepting cycle keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_port  <= RESET_VALUE;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_port <= load_data;
      end
      if (load) begin
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (load && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pio_param_out_hs.sv
// HPS-to-fabric output PIO: Avalon-MM slave with a byte-enabled shadow
// register committed onto a valid/ready output, plus status, control and irq.
module pio_param_out_hs
  import pio_param_out_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           CNT_WIDTH   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    chipselect,
  input  logic [1:0]              address,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    read,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic [DATA_WIDTH-1:0]   out_port,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    irq
);

  logic [DATA_WIDTH-1:0] shadow;
  logic [DATA_WIDTH-1:0] shadow_n;
  logic [CNT_WIDTH-1:0]  acc_cnt;
  logic                  done_flag;
  logic                  overrun;
  logic                  accept;
  ctrl_t                 ctrl;
  logic                  wr;
  logic                  commit;
  logic                  overrun_clr;
  logic                  done_clr;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  unused_read;

  // Reads are not strobe-qualified: readdata is refreshed every cycle.
  assign unused_read = read;

  assign wr          = chipselect & write;
  assign commit      = (wr && address == ADDR_COMMIT && writedata[0]) ||
                       (wr && address == ADDR_DATA && ctrl.auto_commit);
  assign overrun_clr = wr && address == ADDR_STATUS && writedata[ST_OVERRUN];
  assign done_clr    = wr && address == ADDR_STATUS && writedata[ST_DONE];

  // Byte-lane merge of a DATA write; commit sees this merged value directly.
  always_comb begin
    shadow_n = shadow;
    if (wr && address == ADDR_DATA) begin
      for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
        if (byteenable[b]) begin
          shadow_n[b*8 +: 8] = writedata[b*8 +: 8];
        end
      end
    end
  end

  pio_hs_out_reg #(
    .WIDTH      (DATA_WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (commit),
    .load_data  (shadow_n),
    .out_ready  (out_ready),
    .overrun_clr(overrun_clr),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .overrun    (overrun),
    .accept     (accept)
  );

  // Shadow, control, accept counter and sticky done flag (set beats W1C clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= RESET_VALUE;
      ctrl      <= '0;
      acc_cnt   <= '0;
      done_flag <= 1'b0;
    end else begin
      shadow <= shadow_n;
      if (wr && address == ADDR_CTRL && byteenable[0]) begin
        ctrl.auto_commit <= writedata[CTRL_AUTO_COMMIT];
        ctrl.irq_en      <= writedata[CTRL_IRQ_EN];
      end
      if (accept) begin
        acc_cnt <= acc_cnt + CNT_WIDTH'(1);
      end
      if (accept) begin
        done_flag <= 1'b1;
      end else if (done_clr) begin
        done_flag <= 1'b0;
      end
    end
  end

  // Read-data source selected by word offset.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = shadow;
      ADDR_STATUS: begin
        rd_mux[ST_CNT_LSB +: 16] = 16'(acc_cnt);
        rd_mux[ST_DONE]          = done_flag;
        rd_mux[ST_OVERRUN]       = overrun;
        rd_mux[ST_VALID]         = out_valid;
      end
      ADDR_CTRL: begin
        rd_mux[CTRL_AUTO_COMMIT] = ctrl.auto_commit;
        rd_mux[CTRL_IRQ_EN]      = ctrl.irq_en;
      end
      default: rd_mux = '0;
    endcase
  end

  // Registered readdata and irq, both one cycle behind their sources.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= chipselect ? rd_mux : '0;
      irq      <= ctrl.irq_en & ~out_valid & done_flag;
    end
  end

endmodule

// File: tb/tb_pio_param_out_hs.sv
// Directed self-checking bench for pio_param_out_hs.
module tb_pio_param_out_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        read;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic        out_valid;
  logic        out_ready;
  logic        irq;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  pio_param_out_hs #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (16),
    .RESET_VALUE(32'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chipselect(chipselect),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .byteenable(byteenable),
    .read      (read),
    .readdata  (readdata),
    .out_port  (out_port),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .irq       (irq)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    byteenable = be;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    @(posedge clk);
    #1;
    d          = readdata;
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic accept_pulse();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; chipselect = 1'b0; address = '0; write = 1'b0;
    writedata = '0; byteenable = '0; read = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_out_port", out_port, 32'h0);
    check_vec("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check_vec("rst_irq", {31'b0, irq}, 32'h0);
    check_vec("rst_readdata", readdata, 32'h0);
    reset = 1'b0;

    // Explicit commit of a full word.
    bus_write(2'd0, 32'h1234_5678, 4'hF);
    check_vec("no_auto_valid", {31'b0, out_valid}, 32'h0);
    bus_write(2'd1, 32'h1, 4'hF);
    check_vec("commit_port", out_port, 32'h1234_5678);
    check_vec("commit_valid", {31'b0, out_valid}, 32'h1);

    // Overrun on replacing an unaccepted word, then W1C.
    bus_write(2'd0, 32'hAABB_CCDD, 4'hF);
    check_vec("hold_port", out_port, 32'h1234_5678);
    bus_write(2'd1, 32'h1, 4'hF);
    check_vec("overwrite_port", out_port, 32'hAABB_CCDD);
    bus_read(2'd2, rd);
    check_vec("status_overrun", rd, 32'h0000_0003);
    @(posedge clk); #1;
    check_vec("cs_low_readdata", readdata, 32'h0);
    bus_write(2'd2, 32'h2, 4'hF);
    bus_read(2'd2, rd);
    check_vec("status_ovr_clr", rd, 32'h0000_0001);

    // Single accept.
    accept_pulse();
    check_vec("accept_valid", {31'b0, out_valid}, 32'h0);
    check_vec("accept_port_kept", out_port, 32'hAABB_CCDD);
    bus_read(2'd2, rd);
    check_vec("status_accept", rd, 32'h0001_0004);

    // Byte-enable merge and COMMIT with bit0 clear.
    bus_write(2'd0, 32'h0, 4'hF);
    bus_write(2'd0, 32'hFFFF_FFFF, 4'b0101);
    bus_read(2'd0, rd);
    check_vec("byte_merge", rd, 32'h00FF_00FF);
    bus_write(2'd1, 32'h2, 4'hF);
    check_vec("commit_bit0_zero", {31'b0, out_valid}, 32'h0);
    bus_read(2'd1, rd);
    check_vec("commit_reads_0", rd, 32'h0);
    bus_write(2'd2, 32'h4, 4'hF);
    bus_read(2'd2, rd);
    check_vec("status_done_clr", rd, 32'h0001_0000);

    // Auto-commit, including commit in the same cycle as a transfer.
    bus_write(2'd3, 32'h1, 4'h1);
    bus_read(2'd3, rd);
    check_vec("ctrl_auto", rd, 32'h1);
    bus_write(2'd0, 32'h11, 4'hF);
    check_vec("auto_port", out_port, 32'h11);
    check_vec("auto_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1;
    bus_write(2'd0, 32'h55, 4'hF);
    out_ready = 1'b0;
    check_vec("cx_port", out_port, 32'h55);
    check_vec("cx_valid", {31'b0, out_valid}, 32'h1);
    bus_read(2'd2, rd);
    check_vec("cx_status", rd, 32'h0002_0005);
    accept_pulse();
    bus_read(2'd2, rd);
    check_vec("cx_status2", rd, 32'h0003_0004);

    // irq: asserted one cycle after accept, dropped after done W1C.
    bus_write(2'd2, 32'h4, 4'hF);
    bus_write(2'd3, 32'h3, 4'h1);
    bus_write(2'd3, 32'h0, 4'h0);
    bus_read(2'd3, rd);
    check_vec("ctrl_be_gate", rd, 32'h3);
    check_vec("irq_idle", {31'b0, irq}, 32'h0);
    bus_write(2'd0, 32'h77, 4'hF);
    accept_pulse();
    @(posedge clk); #1;
    check_vec("irq_set", {31'b0, irq}, 32'h1);
    bus_write(2'd2, 32'h4, 4'hF);
    @(posedge clk); #1;
    check_vec("irq_clr", {31'b0, irq}, 32'h0);

    // Counter wrap: back-to-back commit+transfer, currently 4 accepts.
    chipselect = 1'b1; write = 1'b1; address = 2'd0;
    writedata = 32'hCAFE_0000; byteenable = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 65531; i++) @(posedge clk);
    #1;
    chipselect = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    bus_read(2'd2, rd);
    check_vec("cnt_ffff", rd, 32'hFFFF_0004);
    bus_write(2'd0, 32'h1, 4'hF);
    accept_pulse();
    bus_read(2'd2, rd);
    check_vec("cnt_wrap", rd, 32'h0000_0004);

    // Reset while a word is pending.
    bus_write(2'd0, 32'h99, 4'hF);
    check_vec("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_vec("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    check_vec("mid_rst_port", out_port, 32'h0);
    bus_read(2'd2, rd);
    check_vec("mid_rst_status", rd, 32'h0);
    bus_read(2'd3, rd);
    check_vec("mid_rst_ctrl", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
